// File: rtl/lsq_ordered_v2_if.sv
// Bundle of dispatch, CDB, ROB, flush, completion and memory-port signals
// around the in-order load/store queue.
interface lsq_ordered_v2_if #(
    parameter int unsigned TAG_W = 4,
    parameter int unsigned CDB_N = 2,
    parameter int unsigned XLEN  = 32
);
    logic                    enq_valid;
    logic                    enq_ready;
    logic                    enq_is_store;
    logic [2:0]              enq_funct3;
    logic [TAG_W-1:0]        enq_tag;
    logic [XLEN-1:0]         enq_base;
    logic [XLEN-1:0]         enq_imm;
    logic [XLEN-1:0]         enq_sdata;
    logic [1:0]              enq_pend;
    logic [CDB_N-1:0]        cdb_valid;
    logic [CDB_N*TAG_W-1:0]  cdb_tag;
    logic [CDB_N*XLEN-1:0]   cdb_data;
    logic [TAG_W-1:0]        rob_head_tag;
    logic                    flush_valid;
    logic [TAG_W-1:0]        flush_tag;
    logic                    res_valid;
    logic [TAG_W-1:0]        res_tag;
    logic [XLEN-1:0]         res_data;
    logic                    mem_read;
    logic                    mem_write;
    logic [31:0]             mem_address;
    logic [3:0]              mem_byte_enable;
    logic [31:0]             mem_wdata;
    logic                    mem_resp;
    logic [31:0]             mem_rdata;

    modport master (
        output enq_valid, enq_is_store, enq_funct3, enq_tag, enq_base, enq_imm,
               enq_sdata, enq_pend, cdb_valid, cdb_tag, cdb_data, rob_head_tag,
               flush_valid, flush_tag, mem_resp, mem_rdata,
        input  enq_ready, res_valid, res_tag, res_data, mem_read, mem_write,
               mem_address, mem_byte_enable, mem_wdata
    );

    modport slave (
        input  enq_valid, enq_is_store, enq_funct3, enq_tag, enq_base, enq_imm,
               enq_sdata, enq_pend, cdb_valid, cdb_tag, cdb_data, rob_head_tag,
               flush_valid, flush_tag, mem_resp, mem_rdata,
        output enq_ready, res_valid, res_tag, res_data, mem_read, mem_write,
               mem_address, mem_byte_enable, mem_wdata
    );
endinterface

// File: rtl/lsq_ordered_v2.sv
// In-order load/store queue: captures operands from the CDB, issues one access
// at a time from the head, supports tag-targeted partial flush with load drain.
module lsq_ordered_v2 #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned CDB_N = 2,
    parameter int unsigned XLEN  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    lsq_ordered_v2_if.slave   bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN} state_e;

    // While a base is pending, addr holds the immediate; while sdata is pending,
    // its low TAG_W bits hold the producer tag.
    typedef struct packed {
        logic             is_store;
        logic [2:0]       f3;
        logic [TAG_W-1:0] tag;
        logic             addr_rdy;
        logic [TAG_W-1:0] btag;
        logic [XLEN-1:0]  addr;
        logic             sdata_rdy;
        logic [XLEN-1:0]  sdata;
    } entry_t;

    entry_t            ent_q [DEPTH];
    entry_t            ent_d [DEPTH];
    entry_t            hd;
    state_e            state_q, state_d;
    logic [PTR_W-1:0]  head_q, head_d, tail;
    logic [CNT_W-1:0]  cnt_q, cnt_d, keep_cnt, fl_off;
    logic              fl_hit, flush_hit, busy_store, squash_head, head_ok;
    logic              enq_fire, deq;
    logic [1:0]        off;
    logic [XLEN:0]     b_cap, s_cap;

    logic              res_valid_q, res_valid_d;
    logic [TAG_W-1:0]  res_tag_q, res_tag_d;
    logic [XLEN-1:0]   res_data_q, res_data_d;
    logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [31:0]       mem_address_q, mem_address_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;

    // Returns {hit, data}; lanes scanned high to low so the lowest lane wins.
    function automatic logic [XLEN:0] cdb_lookup(
        input logic [TAG_W-1:0]       t,
        input logic [CDB_N-1:0]       v,
        input logic [CDB_N*TAG_W-1:0] tg,
        input logic [CDB_N*XLEN-1:0]  d
    );
        logic [XLEN:0] r;
        r = '0;
        for (int l = int'(CDB_N) - 1; l >= 0; l--) begin
            if (v[l] && tg[l*TAG_W +: TAG_W] == t) r = {1'b1, d[l*XLEN +: XLEN]};
        end
        return r;
    endfunction

    function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3, input logic [XLEN-1:0] w);
        case (f3)
            3'b000:  return {{(XLEN-8){w[7]}}, w[7:0]};
            3'b001:  return {{(XLEN-16){w[15]}}, w[15:0]};
            3'b100:  return {{(XLEN-8){1'b0}}, w[7:0]};
            3'b101:  return {{(XLEN-16){1'b0}}, w[15:0]};
            default: return w;
        endcase
    endfunction

    assign bus.enq_ready = (cnt_q < CNT_W'(DEPTH)) && !bus.flush_valid;
    assign enq_fire      = bus.enq_valid && bus.enq_ready;
    assign tail          = head_q + PTR_W'(cnt_q);
    assign hd            = ent_q[head_q];
    assign off           = hd.addr[1:0];

    // First queued entry carrying the flush tag, as an offset from head.
    always_comb begin
        fl_hit = 1'b0;
        fl_off = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (!fl_hit && CNT_W'(i) < cnt_q && ent_q[head_q + PTR_W'(i)].tag == bus.flush_tag) begin
                fl_hit = 1'b1;
                fl_off = CNT_W'(i);
            end
        end
    end

    // An issued store is committed, so a flush landing on it starts at head+1.
    assign busy_store  = (state_q == S_BUSY) && hd.is_store;
    assign flush_hit   = bus.flush_valid && fl_hit;
    assign squash_head = flush_hit && (fl_off == '0) && !busy_store;
    assign keep_cnt    = !flush_hit ? cnt_q :
                         (busy_store && fl_off == '0) ? CNT_W'(1) : fl_off;
    assign head_ok     = (cnt_q != '0) && hd.addr_rdy &&
                         (!hd.is_store || (hd.sdata_rdy && bus.rob_head_tag == hd.tag));

    // Entry update: CDB snoop on every slot, then the enqueue write at tail.
    always_comb begin
        ent_d = ent_q;
        b_cap = '0;
        s_cap = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            b_cap = cdb_lookup(ent_q[i].btag, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
            s_cap = cdb_lookup(ent_q[i].sdata[TAG_W-1:0], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
            if (!ent_q[i].addr_rdy && b_cap[XLEN]) begin
                ent_d[i].addr     = b_cap[XLEN-1:0] + ent_q[i].addr;
                ent_d[i].addr_rdy = 1'b1;
            end
            if (!ent_q[i].sdata_rdy && s_cap[XLEN]) begin
                ent_d[i].sdata     = s_cap[XLEN-1:0];
                ent_d[i].sdata_rdy = 1'b1;
            end
        end
        b_cap = cdb_lookup(bus.enq_base[TAG_W-1:0], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        s_cap = cdb_lookup(bus.enq_sdata[TAG_W-1:0], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        if (enq_fire) begin
            ent_d[tail].is_store  = bus.enq_is_store;
            ent_d[tail].f3        = bus.enq_funct3;
            ent_d[tail].tag       = bus.enq_tag;
            ent_d[tail].btag      = bus.enq_base[TAG_W-1:0];
            ent_d[tail].addr_rdy  = !bus.enq_pend[0] || b_cap[XLEN];
            ent_d[tail].addr      = (bus.enq_pend[0] ? b_cap[XLEN-1:0] : bus.enq_base) + bus.enq_imm;
            ent_d[tail].sdata_rdy = !bus.enq_pend[1] || s_cap[XLEN];
            ent_d[tail].sdata     = (bus.enq_pend[1] && s_cap[XLEN]) ? s_cap[XLEN-1:0] : bus.enq_sdata;
        end
    end

    // Access FSM with next-state, pointer and registered-output computation.
    always_comb begin
        state_d       = state_q;
        head_d        = head_q;
        deq           = 1'b0;
        res_valid_d   = 1'b0;
        res_tag_d     = res_tag_q;
        res_data_d    = res_data_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_address_d = mem_address_q;
        mem_be_d      = mem_be_q;
        mem_wdata_d   = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (head_ok && !squash_head) begin
                    mem_read_d    = !hd.is_store;
                    mem_write_d   = hd.is_store;
                    mem_address_d = {hd.addr[XLEN-1:2], 2'b00};
                    mem_wdata_d   = hd.sdata << {off, 3'b000};
                    case (hd.f3[1:0])
                        2'b00:   mem_be_d = 4'b0001 << off;
                        2'b01:   mem_be_d = 4'b0011 << off;
                        default: mem_be_d = 4'b1111;
                    endcase
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (squash_head) begin
                    if (bus.mem_resp) begin
                        mem_read_d  = 1'b0;
                        mem_write_d = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (bus.mem_resp) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    deq         = 1'b1;
                    head_d      = head_q + PTR_W'(1);
                    res_valid_d = 1'b1;
                    res_tag_d   = hd.tag;
                    res_data_d  = hd.is_store ? hd.sdata :
                                  load_ext(hd.f3, bus.mem_rdata >> {off, 3'b000});
                    state_d     = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (bus.mem_resp) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        cnt_d = keep_cnt - CNT_W'(deq) + CNT_W'(enq_fire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            head_q        <= '0;
            cnt_q         <= '0;
            res_valid_q   <= 1'b0;
            res_tag_q     <= '0;
            res_data_q    <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_be_q      <= '0;
            mem_wdata_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            head_q        <= head_d;
            cnt_q         <= cnt_d;
            res_valid_q   <= res_valid_d;
            res_tag_q     <= res_tag_d;
            res_data_q    <= res_data_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_be_q      <= mem_be_d;
            mem_wdata_q   <= mem_wdata_d;
            for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= ent_d[i];
        end
    end

    assign bus.res_valid       = res_valid_q;
    assign bus.res_tag         = res_tag_q;
    assign bus.res_data        = res_data_q;
    assign bus.mem_read        = mem_read_q;
    assign bus.mem_write       = mem_write_q;
    assign bus.mem_address     = mem_address_q;
    assign bus.mem_byte_enable = mem_be_q;
    assign bus.mem_wdata       = mem_wdata_q;
endmodule
